// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Segment patterns, anode codes and nibble type for the seg7 blocks
// Revision : 1.0
// ============================================================================
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  // Bit order: [6]=A ... [0]=G, active-high
  localparam logic [6:0] SEG7_HEX_0 = 7'b1111110;
  localparam logic [6:0] SEG7_HEX_1 = 7'b0110000;
  localparam logic [6:0] SEG7_HEX_2 = 7'b1101101;
  localparam logic [6:0] SEG7_HEX_3 = 7'b1111001;
  localparam logic [6:0] SEG7_HEX_4 = 7'b0110011;
  localparam logic [6:0] SEG7_HEX_5 = 7'b1011011;
  localparam logic [6:0] SEG7_HEX_6 = 7'b1011111;
  localparam logic [6:0] SEG7_HEX_7 = 7'b1110000;
  localparam logic [6:0] SEG7_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG7_HEX_9 = 7'b1111011;
  localparam logic [6:0] SEG7_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG7_HEX_B = 7'b0011111;
  localparam logic [6:0] SEG7_HEX_C = 7'b1001110;
  localparam logic [6:0] SEG7_HEX_D = 7'b0111101;
  localparam logic [6:0] SEG7_HEX_E = 7'b1001111;
  localparam logic [6:0] SEG7_HEX_F = 7'b1000111;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational seven-segment pattern to hex nibble decoder
// Revision : 1.0
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output nibble_t    nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (pattern)
      SEG7_HEX_0: nibble = 4'h0;
      SEG7_HEX_1: nibble = 4'h1;
      SEG7_HEX_2: nibble = 4'h2;
      SEG7_HEX_3: nibble = 4'h3;
      SEG7_HEX_4: nibble = 4'h4;
      SEG7_HEX_5: nibble = 4'h5;
      SEG7_HEX_6: nibble = 4'h6;
      SEG7_HEX_7: nibble = 4'h7;
      SEG7_HEX_8: nibble = 4'h8;
      SEG7_HEX_9: nibble = 4'h9;
      SEG7_HEX_A: nibble = 4'hA;
      SEG7_HEX_B: nibble = 4'hB;
      SEG7_HEX_C: nibble = 4'hC;
      SEG7_HEX_D: nibble = 4'hD;
      SEG7_HEX_E: nibble = 4'hE;
      SEG7_HEX_F: nibble = 4'hF;
      default:    hit    = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_mux_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg7_mux_capture
// Brief    : Recovers a 16-bit hex value from a multiplexed 4-digit 7-seg bus.
//            Define SEG7_ACTIVE_LOW_EN for boards with active-low segments.
// Revision : 1.0
// ============================================================================
module seg7_mux_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  anodes,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

  logic [6:0]     r_s_seg;
  logic [3:0]     r_s_an;
  logic [6:0]     r_p_seg;
  logic [3:0]     r_p_an;
  logic [3:0]     r_cnt;
  logic [3:0]     r_seen;
  nibble_t [3:0]  r_shadow;
  logic [15:0]    r_value;
  logic           r_value_valid;
  logic           r_seg_err;
  logic           r_anode_err;

  logic           w_same;
  logic [3:0]     w_cnt_next;
  logic           w_accept;
  logic [6:0]     w_seg;
  logic           w_an_blank;
  logic           w_an_onehot;
  logic [1:0]     w_idx;
  nibble_t        w_nib;
  logic           w_hit;
  logic [3:0]     w_seen_upd;
  nibble_t [3:0]  w_frame;

  // Comparison always uses the raw sample so both polarities time identically
`ifdef SEG7_ACTIVE_LOW_EN
  assign w_seg = ~r_s_seg;
`else
  assign w_seg = r_s_seg;
`endif

  assign w_same     = (r_s_seg == r_p_seg) && (r_s_an == r_p_an);
  assign w_cnt_next = !w_same ? 4'd1 :
                      (r_cnt >= c_stable) ? c_stable : r_cnt + 4'd1;
  // Fires once per run: the saturated, unchanged case is suppressed
  assign w_accept   = (w_cnt_next == c_stable) && !(w_same && (r_cnt == c_stable));
  assign w_an_blank = (r_s_an == AN_NONE);

  always_comb begin
    w_an_onehot = 1'b1;
    w_idx       = 2'd0;
    case (r_s_an)
      AN_DIG0: w_idx = 2'd0;
      AN_DIG1: w_idx = 2'd1;
      AN_DIG2: w_idx = 2'd2;
      AN_DIG3: w_idx = 2'd3;
      default: w_an_onehot = 1'b0;
    endcase
  end

  seg7_decode u_decode (
    .pattern (w_seg),
    .nibble  (w_nib),
    .hit     (w_hit)
  );

  always_comb begin
    w_frame        = r_shadow;
    w_frame[w_idx] = w_nib;
  end

  assign w_seen_upd = r_seen | (4'b0001 << w_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_seg       <= 7'd0;
      r_s_an        <= AN_NONE;
      r_p_seg       <= 7'd0;
      r_p_an        <= AN_NONE;
      r_cnt         <= 4'd0;
      r_seen        <= 4'd0;
      r_shadow      <= '0;
      r_value       <= 16'h0000;
      r_value_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      r_anode_err   <= 1'b0;
    end else begin
      r_s_seg       <= seg;
      r_s_an        <= anodes;
      r_p_seg       <= r_s_seg;
      r_p_an        <= r_s_an;
      r_cnt         <= w_cnt_next;
      r_value_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      r_anode_err   <= 1'b0;
      if (w_accept && !w_an_blank) begin
        if (!w_an_onehot) begin
          r_anode_err <= 1'b1;
        end else if (!w_hit) begin
          r_seg_err <= 1'b1;
        end else begin
          r_shadow[w_idx] <= w_nib;
          if (w_seen_upd == 4'hF) begin
            r_value       <= w_frame;
            r_value_valid <= 1'b1;
            r_seen        <= 4'd0;
          end else begin
            r_seen <= w_seen_upd;
          end
        end
      end
    end
  end

  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign seg_err     = r_seg_err;
  assign anode_err   = r_anode_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_mux_capture
// Brief    : Self-checking bench for seg7_mux_capture (STABLE_CYCLES 1 and 3)
// Revision : 1.0
// ============================================================================
module tb_seg7_mux_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  anodes;
  logic [15:0] v1, v3;
  logic        vv1, vv3, se1, se3, ae1, ae3;

  always #5 clk = ~clk;

  seg7_mux_capture #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .seg(seg), .anodes(anodes),
    .value(v1), .value_valid(vv1), .seg_err(se1), .anode_err(ae1)
  );

  seg7_mux_capture #(.STABLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .seg(seg), .anodes(anodes),
    .value(v3), .value_valid(vv3), .seg_err(se3), .anode_err(ae3)
  );

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] ev;
    logic        evv;
    logic        ese;
    logic        eae;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int vv1_cnt, vv3_cnt, se1_cnt;

  logic [6:0] hex_tbl [16];
  int         k_of [2];

  // Reference model state, one per instance (0: K=1, 1: K=3)
  logic [6:0]  m_pseg [2];
  logic [3:0]  m_pan  [2];
  int          m_run  [2];
  logic [3:0]  m_seen [2];
  logic [3:0]  m_nib  [2][4];
  logic [15:0] m_value[2];
  logic [15:0] e_val  [2];
  logic        e_vv   [2];
  logic        e_se   [2];
  logic        e_ae   [2];

  function automatic logic [6:0] phys(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_sample(input int m, input logic [6:0] s, input logic [3:0] a);
    int zeros, idx, nib;
    if (s == m_pseg[m] && a == m_pan[m]) m_run[m]++;
    else m_run[m] = 1;
    m_pseg[m] = s;
    m_pan[m]  = a;
    e_vv[m] = 1'b0;
    e_se[m] = 1'b0;
    e_ae[m] = 1'b0;
    if (m_run[m] == k_of[m]) begin
      zeros = 0;
      idx   = 0;
      for (int b = 0; b < 4; b++) if (!a[b]) begin zeros++; idx = b; end
      if (zeros > 1) e_ae[m] = 1'b1;
      else if (zeros == 1) begin
        nib = -1;
        for (int t = 0; t < 16; t++) if (hex_tbl[t] == phys(s)) nib = t;
        if (nib < 0) e_se[m] = 1'b1;
        else begin
          m_nib[m][idx]  = 4'(nib);
          m_seen[m][idx] = 1'b1;
          if (m_seen[m] == 4'hF) begin
            m_value[m] = {m_nib[m][3], m_nib[m][2], m_nib[m][1], m_nib[m][0]};
            e_vv[m]    = 1'b1;
            m_seen[m]  = 4'h0;
          end
        end
      end
    end
    e_val[m] = m_value[m];
  endtask

  task automatic model_reset(input int m);
    m_pseg[m]  = 7'd0;
    m_pan[m]   = 4'hF;
    m_run[m]   = 0;
    m_seen[m]  = 4'h0;
    m_value[m] = 16'h0;
    for (int i = 0; i < 4; i++) m_nib[m][i] = 4'h0;
    model_sample(m, 7'd0, 4'hF);
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] a);
    seg    = s;
    anodes = a;
    @(posedge clk);
    #1;
    chk("k1_value", v1, e_val[0]);
    chk("k1_valid", 16'(vv1), 16'(e_vv[0]));
    chk("k1_seg_err", 16'(se1), 16'(e_se[0]));
    chk("k1_anode_err", 16'(ae1), 16'(e_ae[0]));
    chk("k3_value", v3, e_val[1]);
    chk("k3_valid", 16'(vv3), 16'(e_vv[1]));
    chk("k3_seg_err", 16'(se3), 16'(e_se[1]));
    chk("k3_anode_err", 16'(ae3), 16'(e_ae[1]));
    vv1_cnt += int'(vv1);
    vv3_cnt += int'(vv3);
    se1_cnt += int'(se1);
    model_sample(0, s, a);
    model_sample(1, s, a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_value1", v1, 16'h0);
    chk("rst_value3", v3, 16'h0);
    chk("rst_pulses1", {13'd0, vv1, se1, ae1}, 16'h0);
    chk("rst_pulses3", {13'd0, vv3, se3, ae3}, 16'h0);
    model_reset(0);
    model_reset(1);
  endtask

  task automatic hold_digit(input int idx, input int nib, input int cycles);
    repeat (cycles) drive(phys(hex_tbl[nib]), ~(4'b0001 << idx));
  endtask

  vec_t tbl [20];

  initial begin
    hex_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    k_of = '{1, 3};
    // Expected outputs are those caused by the vector, visible one edge later
    tbl[0]  = '{4'b1110, 7'b1000111, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b1101, 7'b1101101, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b1011, 7'b1110111, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0111, 7'b0110000, 16'h1A2F, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'b1110, 7'b1000111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b1101, 7'b1101101, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1011, 7'b1110111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0111, 7'b0110000, 16'h1A2F, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{4'b1110, 7'b1000111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1101, 7'b0000001, 16'h1A2F, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b1011, 7'b1110111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0111, 7'b0110000, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'b1110, 7'b1000111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'b1101, 7'b1101101, 16'h1A2F, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{4'b1100, 7'b1101101, 16'h1A2F, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{4'b1111, 7'b0000000, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{4'b1110, 7'b1000111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{4'b1101, 7'b1101101, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{4'b1011, 7'b1110111, 16'h1A2F, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{4'b0111, 7'b0110000, 16'h1A2F, 1'b1, 1'b0, 1'b0};

    vv1_cnt = 0; vv3_cnt = 0; se1_cnt = 0;
    rst = 1'b1; seg = 7'd0; anodes = 4'hF;
    repeat (2) @(posedge clk);
    do_reset();

    // Directed rotation with bad segment, bad anode and blank (K=1)
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) drive(phys(tbl[i].seg), tbl[i].an);
      else drive(phys(7'd0), 4'hF);
      if (i > 0) begin
        chk("tbl_value", v1, tbl[i-1].ev);
        chk("tbl_flags", {13'd0, vv1, se1, ae1},
            {13'd0, tbl[i-1].evv, tbl[i-1].ese, tbl[i-1].eae});
      end
    end

    // K=3: 2-cycle glitches ignored, 5-cycle holds accepted once each
    do_reset();
    vv3_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      hold_digit((d + 1) % 4, 8, 2);
      hold_digit(d, (d == 0) ? 4'hF : (d == 1) ? 4'h2 : (d == 2) ? 4'hA : 4'h1, 5);
    end
    drive(phys(7'd0), 4'hF);
    chk("k3_hold_valid_count", 16'(vv3_cnt), 16'd1);
    chk("k3_hold_value", v3, 16'h1A2F);

    // Reset after two accepted digits discards them
    hold_digit(0, 4'hE, 5);
    hold_digit(1, 4'hD, 5);
    do_reset();
    vv3_cnt = 0;
    hold_digit(2, 4'h0, 5);
    hold_digit(3, 4'hC, 5);
    drive(phys(7'd0), 4'hF);
    chk("rst_partial_no_valid", 16'(vv3_cnt), 16'd0);
    chk("rst_partial_value", v3, 16'h0);
    hold_digit(0, 4'hE, 5);
    hold_digit(1, 4'hD, 5);
    drive(phys(7'd0), 4'hF);
    chk("rst_recapture_valid", 16'(vv3_cnt), 16'd1);
    chk("rst_recapture_value", v3, 16'hC0DE);

    // Inverted (active-low) patterns for BEEF, driven raw
    do_reset();
    se1_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      drive(~hex_tbl[4'hF], 4'b1110);
      drive(~hex_tbl[4'hE], 4'b1101);
      drive(~hex_tbl[4'hE], 4'b1011);
      drive(~hex_tbl[4'hB], 4'b0111);
    end
    drive(7'd0, 4'hF);
`ifdef SEG7_ACTIVE_LOW_EN
    chk("beef_value", v1, 16'hBEEF);
`else
    chk("beef_seg_err_seen", 16'(se1_cnt > 0), 16'd1);
`endif

    // Randomized bursts against the model
    for (int n = 0; n < 400; n++) begin
      int kind, hold;
      logic [6:0] s;
      logic [3:0] a;
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 5);
      a = ~(4'b0001 << $urandom_range(0, 3));
      s = phys(hex_tbl[$urandom_range(0, 15)]);
      if (kind == 0) a = 4'hF;
      else if (kind == 1) a = 4'($urandom_range(0, 15));
      else if (kind == 2) s = 7'($urandom_range(0, 127));
      repeat (hold) drive(s, a);
      if (n == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
